dpram_arbiter: RTL and testbench
================================

DPRAM_ARBITER -- requirements
Module: dpram_arbiter

Interface
REQ-001: Parameter AW, default 2, is the RAM word-address width.
REQ-002: Parameter DW, default 4, is the RAM word width.
REQ-003: Port clck, input, 1 bit, is the single clock; all state updates on its rising edge.
REQ-004: Port rst_n, input, 1 bit, is an asynchronous active-low reset.
REQ-005: Port a_req, input, 1 bit, is the requester A access request, held until a_ack.
REQ-006: Port a_we, input, 1 bit, selects write (1) or read (0) for A; stable while a_req=1.
REQ-007: Port a_addr, input, AW bits, is the A word address; stable while a_req=1.
REQ-008: Port a_wdata, input, DW bits, is the A write data; stable while a_req=1.
REQ-009: Port a_ack, output, 1 bit, is a one-cycle completion pulse for A.
REQ-010: Port a_rdata, output, DW bits, is A read data, valid in the a_ack cycle and held until the next A read completes.
REQ-011: Ports b_req, b_we, b_addr, b_wdata, b_ack and b_rdata SHALL mirror the A ports exactly for requester B.
REQ-012: Port ram_address, output, AW bits, is the RAM write address.
REQ-013: Ports ram_data_a and ram_data_b, output, DW bits each, are the RAM write-data lanes.
REQ-014: Port ram_write, output, 2 bits, is the RAM write-select: 00 none, 10 lane a, 01 lane b.
REQ-015: Port ram_read, output, 1 bit, is the RAM read-port enable.
REQ-016: Port ram_read_addr, output, AW bits, is the RAM read address.
REQ-017: Port ram_rd_bus, input, (2^AW)*DW bits, is the RAM read bus; word k sits at bits [k*DW +: DW].
REQ-018: Port busy, output, 1 bit, is high whenever the FSM is not IDLE.

Function
REQ-019: The FSM SHALL use states IDLE, GRANT and ACK; IDLE->GRANT when any req=1 in IDLE, GRANT->ACK always, ACK->IDLE always.
REQ-020: On the IDLE->GRANT edge the arbiter SHALL latch the winner (A/B), its we, addr and wdata into internal registers.
REQ-021: Arbitration SHALL be round-robin: if only one req=1 that requester wins; if both are 1 the requester not granted last wins; after reset A has priority.
REQ-022: last_grant SHALL update only on the IDLE->GRANT edge.
REQ-023: In GRANT with a write: ram_address=latched addr; winner A drives ram_data_a=wdata and ram_write=10; winner B drives ram_data_b=wdata and ram_write=01; ram_write is nonzero for exactly one cycle per write.
REQ-024: In GRANT with a read: ram_read=1 and ram_read_addr=latched addr; at the end of GRANT the winner's rdata SHALL capture ram_rd_bus[addr*DW +: DW].
REQ-025: In every non-GRANT cycle ram_write SHALL be 00 and ram_read SHALL be 0; ram_address, ram_read_addr and the data lanes SHALL drive 0.
REQ-026: The winner's ack SHALL be high in the ACK state only; the loser's ack SHALL stay 0.
REQ-027: Latency: req sampled at edge N gives GRANT in cycle N..N+1 and ack in cycle N+1..N+2 (2 cycles); a losing requester completes no earlier than 3 cycles after the winner.
REQ-028: A requester SHALL deassert req in the cycle after its ack; a req still high in IDLE after ACK SHALL be treated as a new request.
REQ-029: req changes during GRANT or ACK SHALL not affect the transaction in flight.
REQ-030: Accesses are fully serialised, so a read issued after a completed write to the same address SHALL return the written data.

Reset
REQ-031: With rst_n=0 the block SHALL asynchronously enter IDLE and drive a_ack=b_ack=0, a_rdata=b_rdata=0, ram_write=00, ram_read=0, busy=0, and last_grant=B (A wins first).
REQ-032: A reset during GRANT SHALL abort the transaction; ram_write SHALL drop to 00 immediately and no ack SHALL be issued.
REQ-033: Release of rst_n SHALL take effect at the next rising edge of clck; no request is sampled in the release cycle.

Verification
REQ-034: A alone writes addr 2, data 4'hA -> ram_write=10 and ram_address=2 for one cycle; a_ack 2 cycles after req; b_ack stays 0.
REQ-035: A and B request simultaneously after reset, both writes (A addr 0 data 3, B addr 0 data 5) -> A is served first, then B; ram_write sequence is 10, then 01; final word 0 = 5.
REQ-036: B reads addr 3 holding 4'h7 -> ram_read=1 with ram_read_addr=3 for one cycle; b_rdata=7 in the b_ack cycle.
REQ-037: Both requesters hold req for four transactions -> grants alternate A, B, A, B; no ack is asserted twice consecutively for the same requester.
REQ-038: rst_n pulsed low during GRANT of an A write -> ram_write=00 immediately, a_ack never asserted, busy=0; after release a fresh A request completes normally.
REQ-039: A writes 4'hC to addr 1, then reads addr 1 -> a_rdata=C.

Source files
------------

// File: rtl/dpram_arbiter_if.sv
// Bundle of the two requester handshakes and the RAM-side bus of dpram_arbiter.
// The slave modport is the arbiter's view; the master modport is the requesters/RAM side.
interface dpram_arbiter_if #(
    parameter int unsigned AW = 2,
    parameter int unsigned DW = 4
);
    logic                   a_req;
    logic                   a_we;
    logic [AW-1:0]          a_addr;
    logic [DW-1:0]          a_wdata;
    logic                   a_ack;
    logic [DW-1:0]          a_rdata;

    logic                   b_req;
    logic                   b_we;
    logic [AW-1:0]          b_addr;
    logic [DW-1:0]          b_wdata;
    logic                   b_ack;
    logic [DW-1:0]          b_rdata;

    logic [AW-1:0]          ram_address;
    logic [DW-1:0]          ram_data_a;
    logic [DW-1:0]          ram_data_b;
    logic [1:0]             ram_write;
    logic                   ram_read;
    logic [AW-1:0]          ram_read_addr;
    logic [(2**AW)*DW-1:0]  ram_rd_bus;

    logic                   busy;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        input  b_req, b_we, b_addr, b_wdata,
        input  ram_rd_bus,
        output a_ack, a_rdata, b_ack, b_rdata,
        output ram_address, ram_data_a, ram_data_b, ram_write, ram_read, ram_read_addr,
        output busy
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        output b_req, b_we, b_addr, b_wdata,
        output ram_rd_bus,
        input  a_ack, a_rdata, b_ack, b_rdata,
        input  ram_address, ram_data_a, ram_data_b, ram_write, ram_read, ram_read_addr,
        input  busy
    );
endinterface

// File: rtl/dpram_arbiter.sv
// Round-robin arbiter serialising two requesters onto a single RAM port.
// Each access takes IDLE -> GRANT (RAM strobe) -> ACK (completion pulse).
module dpram_arbiter #(
    parameter int unsigned AW = 2,
    parameter int unsigned DW = 4
) (
    input logic            clck,
    input logic            rst_n,
    dpram_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GRANT = 2'd1;
    localparam logic [1:0] ACK   = 2'd2;

    logic [1:0]    r_state;
    logic          r_armed;
    logic          r_last_b;
    logic          r_win;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_a_rdata;
    logic [DW-1:0] r_b_rdata;

    logic          w_any_req;
    logic          w_pick_b;
    logic [31:0]   w_rd_base;
    logic [DW-1:0] w_rd_word;
    logic          w_grant;
    logic          w_wr;
    logic          w_rd;

    assign w_any_req = bus.a_req | bus.b_req;
    // On a tie the requester not served last wins.
    assign w_pick_b  = (bus.a_req & bus.b_req) ? ~r_last_b : bus.b_req;
    assign w_rd_base = 32'(r_addr) * DW;
    assign w_rd_word = bus.ram_rd_bus[w_rd_base +: DW];

    // r_armed keeps the first edge after reset release from sampling requests.
    always_ff @(posedge clck or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_armed   <= 1'b0;
            r_last_b  <= 1'b1;
            r_win     <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_a_rdata <= '0;
            r_b_rdata <= '0;
        end else begin
            r_armed <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (r_armed && w_any_req) begin
                        r_state  <= GRANT;
                        r_win    <= w_pick_b;
                        r_last_b <= w_pick_b;
                        r_we     <= w_pick_b ? bus.b_we    : bus.a_we;
                        r_addr   <= w_pick_b ? bus.b_addr  : bus.a_addr;
                        r_wdata  <= w_pick_b ? bus.b_wdata : bus.a_wdata;
                    end
                end
                GRANT: begin
                    r_state <= ACK;
                    if (!r_we) begin
                        if (r_win) r_b_rdata <= w_rd_word;
                        else       r_a_rdata <= w_rd_word;
                    end
                end
                ACK:     r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_grant = (r_state == GRANT);
    assign w_wr    = w_grant & r_we;
    assign w_rd    = w_grant & ~r_we;

    // RAM controls are decoded from state so an asynchronous reset drops them at once.
    assign bus.ram_write     = w_wr ? (r_win ? 2'b01 : 2'b10) : 2'b00;
    assign bus.ram_address   = w_wr ? r_addr : '0;
    assign bus.ram_data_a    = (w_wr && !r_win) ? r_wdata : '0;
    assign bus.ram_data_b    = (w_wr &&  r_win) ? r_wdata : '0;
    assign bus.ram_read      = w_rd;
    assign bus.ram_read_addr = w_rd ? r_addr : '0;

    assign bus.a_ack   = (r_state == ACK) & ~r_win;
    assign bus.b_ack   = (r_state == ACK) &  r_win;
    assign bus.a_rdata = r_a_rdata;
    assign bus.b_rdata = r_b_rdata;
    assign bus.busy    = (r_state != IDLE);
endmodule

// File: tb/tb_dpram_arbiter.sv
// Randomised bench for dpram_arbiter: a transaction-level schedule model predicts every
// RAM strobe, ack and read result cycle by cycle; a simple RAM array answers reads.
module tb_dpram_arbiter;
    localparam int unsigned AW = 2;
    localparam int unsigned DW = 4;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } op_t;

    logic clck  = 1'b0;
    logic rst_n = 1'b0;

    dpram_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    dpram_arbiter #(.AW(AW), .DW(DW)) dut (
        .clck  (clck),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clck = ~clck;

    // Environment RAM
    logic [DW-1:0] ram_mem [4] = '{4'h4, 4'h5, 4'h6, 4'h7};

    always @(posedge clck) begin
        if (bus.ram_write == 2'b10)      ram_mem[bus.ram_address] <= bus.ram_data_a;
        else if (bus.ram_write == 2'b01) ram_mem[bus.ram_address] <= bus.ram_data_b;
    end

    always_comb begin
        bus.ram_rd_bus = '0;
        for (int i = 0; i < 4; i++) bus.ram_rd_bus[i*DW +: DW] = ram_mem[i];
    end

    // Reference model state
    logic [DW-1:0] mdl_mem [4] = '{4'h4, 4'h5, 4'h6, 4'h7};
    int            k;
    int            free_at;
    int            t_edge;
    bit            last_b;
    bit            t_active;
    bit            t_win;
    bit            t_we;
    logic [AW-1:0] t_addr;
    logic [DW-1:0] t_data;
    logic [DW-1:0] exp_a_rd;
    logic [DW-1:0] exp_b_rd;
    bit            in_grant;
    bit            in_ack;
    bit            directed;
    bit            abort_armed;
    op_t           qa [$];
    op_t           qb [$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, k);
        end
    endtask

    // A grant at edge g puts the strobe in the cycle after g, the ack after g+1, and the
    // arbiter can next sample requests at g+3.
    task automatic model_edge();
        k++;
        if (t_active && k == t_edge + 1) begin
            if (t_we)       mdl_mem[t_addr] = t_data;
            else if (t_win) exp_b_rd = mdl_mem[t_addr];
            else            exp_a_rd = mdl_mem[t_addr];
        end
        if (t_active && k == t_edge + 2) t_active = 1'b0;
        if (k >= free_at && (bus.a_req || bus.b_req)) begin
            t_win    = (bus.a_req && bus.b_req) ? !last_b : bus.b_req;
            last_b   = t_win;
            t_active = 1'b1;
            t_edge   = k;
            free_at  = k + 3;
            t_we     = t_win ? bus.b_we    : bus.a_we;
            t_addr   = t_win ? bus.b_addr  : bus.a_addr;
            t_data   = t_win ? bus.b_wdata : bus.a_wdata;
        end
    endtask

    task automatic check_outputs();
        logic [1:0] exp_wr;
        in_grant = t_active && k == t_edge;
        in_ack   = t_active && k == t_edge + 1;
        exp_wr   = (in_grant && t_we) ? (t_win ? 2'b01 : 2'b10) : 2'b00;
        check("ram_write", 32'(bus.ram_write), 32'(exp_wr));
        check("ram_address", 32'(bus.ram_address), (in_grant && t_we) ? 32'(t_addr) : 0);
        check("ram_data_a", 32'(bus.ram_data_a), (in_grant && t_we && !t_win) ? 32'(t_data) : 0);
        check("ram_data_b", 32'(bus.ram_data_b), (in_grant && t_we && t_win) ? 32'(t_data) : 0);
        check("ram_read", 32'(bus.ram_read), 32'(in_grant && !t_we));
        check("ram_read_addr", 32'(bus.ram_read_addr), (in_grant && !t_we) ? 32'(t_addr) : 0);
        check("a_ack", 32'(bus.a_ack), 32'(in_ack && !t_win));
        check("b_ack", 32'(bus.b_ack), 32'(in_ack && t_win));
        check("a_rdata", 32'(bus.a_rdata), 32'(exp_a_rd));
        check("b_rdata", 32'(bus.b_rdata), 32'(exp_b_rd));
        check("busy", 32'(bus.busy), 32'(in_grant || in_ack));
    endtask

    task automatic model_reset();
        t_active = 1'b0;
        last_b   = 1'b1;
        exp_a_rd = '0;
        exp_b_rd = '0;
        in_grant = 1'b0;
        in_ack   = 1'b0;
    endtask

    task automatic drive();
        bit a_done;
        bit b_done;
        op_t o;
        a_done = in_ack && !t_win;
        b_done = in_ack && t_win;
        if (a_done) begin bus.a_req = 1'b0; qa.delete(0); end
        if (b_done) begin bus.b_req = 1'b0; qb.delete(0); end
        if (!bus.a_req && !a_done && qa.size() > 0 && (directed || $urandom_range(0, 1) == 1)) begin
            o = qa[0];
            bus.a_req = 1'b1; bus.a_we = o.we; bus.a_addr = o.addr; bus.a_wdata = o.data;
        end
        if (!bus.b_req && !b_done && qb.size() > 0 && (directed || $urandom_range(0, 1) == 1)) begin
            o = qb[0];
            bus.b_req = 1'b1; bus.b_we = o.we; bus.b_addr = o.addr; bus.b_wdata = o.data;
        end
    endtask

    task automatic step();
        @(posedge clck);
        model_edge();
        @(negedge clck);
        check_outputs();
        if (abort_armed && in_grant && t_we && !t_win) begin
            abort_armed = 1'b0;
            #2 rst_n = 1'b0;
            #1;
            check("abort_ram_write", 32'(bus.ram_write), 0);
            check("abort_busy", 32'(bus.busy), 0);
            check("abort_a_ack", 32'(bus.a_ack), 0);
            bus.a_req = 1'b0;
            model_reset();
            @(posedge clck);
            k++;
            @(negedge clck);
            check("abort_hold_a_ack", 32'(bus.a_ack), 0);
            rst_n   = 1'b1;
            free_at = k + 2;
        end
        drive();
    endtask

    task automatic do_reset();
        @(negedge clck);
        rst_n = 1'b0;
        #1;
        check("rst_a_ack", 32'(bus.a_ack), 0);
        check("rst_b_ack", 32'(bus.b_ack), 0);
        check("rst_a_rdata", 32'(bus.a_rdata), 0);
        check("rst_b_rdata", 32'(bus.b_rdata), 0);
        check("rst_ram_write", 32'(bus.ram_write), 0);
        check("rst_ram_read", 32'(bus.ram_read), 0);
        check("rst_busy", 32'(bus.busy), 0);
        repeat (2) begin @(posedge clck); k++; end
        @(negedge clck);
        rst_n = 1'b1;
        model_reset();
        free_at = k + 2;
    endtask

    task automatic run_phase(input int max_cycles);
        int n = 0;
        drive();
        while ((qa.size() > 0 || qb.size() > 0 || t_active) && n < max_cycles) begin
            step();
            n++;
        end
        check("phase_done", 32'(n < max_cycles), 1);
        for (int i = 0; i < 4; i++) check("ram_word", 32'(ram_mem[i]), 32'(mdl_mem[i]));
    endtask

    function automatic op_t mk(input logic we, input int addr, input int data);
        op_t o;
        o.we   = we;
        o.addr = AW'(addr);
        o.data = DW'(data);
        return o;
    endfunction

    initial begin
        op_t o;
        bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_addr = '0; bus.a_wdata = '0;
        bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_addr = '0; bus.b_wdata = '0;
        k = 0; free_at = 0; t_edge = 0; t_we = 1'b0; t_win = 1'b0; t_addr = '0; t_data = '0;
        directed = 1'b1;
        abort_armed = 1'b0;
        model_reset();
        do_reset();

        // Simultaneous writes to word 0 right after reset: A first, B's value survives.
        qa.push_back(mk(1'b1, 0, 3));
        qb.push_back(mk(1'b1, 0, 5));
        run_phase(50);
        check("word0_final", 32'(ram_mem[0]), 5);

        // A alone writes 4'hA to address 2.
        qa.push_back(mk(1'b1, 2, 4'hA));
        run_phase(50);

        // B reads address 3, which still holds its initial 4'h7.
        qb.push_back(mk(1'b0, 3, 0));
        run_phase(50);
        check("b_read3", 32'(bus.b_rdata), 7);

        // Write then read back through A.
        qa.push_back(mk(1'b1, 1, 4'hC));
        qa.push_back(mk(1'b0, 1, 0));
        run_phase(50);
        check("a_readback", 32'(bus.a_rdata), 4'hC);

        // Both requesters saturated for four transactions each.
        for (int i = 0; i < 4; i++) begin
            qa.push_back(mk(1'b1, i, i + 8));
            qb.push_back(mk(1'b0, i, 0));
        end
        run_phase(100);

        // Reset in the middle of an A write, then the same request reissued.
        abort_armed = 1'b1;
        qa.push_back(mk(1'b1, 2, 4'h9));
        run_phase(60);
        check("abort_consumed", 32'(abort_armed), 0);

        // Random traffic with random request timing.
        directed = 1'b0;
        for (int i = 0; i < 40; i++) begin
            o.we   = 1'($urandom_range(0, 1));
            o.addr = AW'($urandom_range(0, 3));
            o.data = DW'($urandom_range(0, 15));
            qa.push_back(o);
            o.we   = 1'($urandom_range(0, 1));
            o.addr = AW'($urandom_range(0, 3));
            o.data = DW'($urandom_range(0, 15));
            qb.push_back(o);
        end
        run_phase(2000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
